fpmul_param: RTL and testbench
==============================

# fpmul_param

Parametrised multi-cycle IEEE-754-style floating-point multiplier. It generalises the single-precision controller/datapath multiplier to arbitrary exponent and mantissa widths, and adds four selectable rounding modes and a Busy output. It performs a radix-2 shift-add mantissa multiply, one bit per cycle, and uses a Start/Done handshake. It sits beside the existing FP units and is driven by the same sequencing logic.

## Interface
- EW, 8, exponent field width (≥3); bias = 2^(EW-1)-1
- MW, 23, stored fraction width (≥2); word width W = 1+EW+MW
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- RM  in  2  rounding mode, captured with operands: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (−inf)
- A, B  in  W  operands, captured on accepted Start
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle pulse; P/flags valid from this cycle
- P  out  W  product
- UF, OF, NaNF, InfF, DNF, ZF  out  1 each  underflow, overflow, NaN result, infinite result, denormal input seen, zero result

## Operation
- States: IDLE, CHECK, MULT, NORM, ROUND, DONE.
- IDLE: when Start=1, register A, B and RM, then go to CHECK. P and flags keep their previous values until the next result is written.
- CHECK: classify the operands; exp==0 with frac≠0 counts as denormal.
  - Denormal operand: set DNF=1 and treat the operand as ±0.
  - NaN operand, or 0×Inf: P = canonical qNaN {0, all-ones exp, 1, zeros}, NaNF=1.
  - Inf × nonzero: P = ±Inf, InfF=1.
  - Zero operand: P = ±0, ZF=1.
  - All special cases then go to DONE.
  - Otherwise: result sign = SA^SB; exponent = EA+EB−bias, held in EW+2-bit signed form; clear the 2(MW+1)-bit accumulator; load bit counter = MW+1; go to MULT.
- MULT: each cycle, add the multiplicand when multiplier LSB=1, shift, decrement the counter. Leave to NORM when the counter reaches 0, i.e. after exactly MW+1 cycles.
- NORM: if product MSB=1, shift right 1 and add 1 to the exponent. Form guard, round and sticky from the discarded bits.
- ROUND: apply RM.
  - RNE: ties go to even.
  - RUP: increment if inexact and positive.
  - RDN: increment if inexact and negative.
  - RTZ: truncate.
  - A mantissa carry-out renormalises and increments the exponent.
  - Biased exponent ≥ 2^EW−1: OF=1. Result is ±Inf with InfF=1 for RNE, RUP-positive and RDN-negative; otherwise ±max finite.
  - Biased exponent ≤ 0: UF=1, ZF=1, P = signed zero (flush, no subnormal output).
  - Write P and flags, then go to DONE.
- DONE: Done=1 for this cycle only, then go to IDLE. Start is ignored in every state except IDLE.
- At the start of each new operation, every flag not set by that operation is cleared (in CHECK).

## Timing
- Reset (async, Rst=0): state=IDLE, P=0, all flags 0, Done=0, Busy=0. Takes effect immediately regardless of state.
  - Reset mid-operation aborts the operation; no Done is produced.
  - Operation resumes on the first Clk edge after Rst is released.
- Start accepted at edge k; Busy=1 from edge k.
- Special operand: Done is high in the cycle after edge k+2.
- Normal operand: Done is high in the cycle after edge k+MW+4 (27 cycles for MW=23; 14 for MW=10).
- Busy stays 1 through the DONE cycle and drops at the following edge. A Start held high at that point is accepted on the next edge, so back-to-back operations have 1 idle cycle between them.
- P and flags change only at the ROUND→DONE or CHECK→DONE edge, or on reset.

## Test plan
- Reset, then 0x3FC00000×0x40000000, RM=00 (EW=8, MW=23) → P=0x40400000, all flags 0, Done a single pulse 27 cycles after Start, Busy high for 28 cycles.
- 0x3F800001×0x3F800001 under each mode → RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003. Sign-flipped operand A (0xBF800001) with RDN → 0xBF800003.
- 0x7F000000×0x7F000000 → RNE: 0x7F800000 with OF=1, InfF=1. RTZ: 0x7F7FFFFF with OF=1, InfF=0. Then 0x00800000×0x00800000 → 0x00000000 with UF=1, ZF=1.
- 0x7F800000×0x00000000 → 0x7FC00000 with NaNF=1, Done 2 cycles after Start. 0x00000001×0x3F800000 → 0x00000000 with DNF=1, ZF=1.
- Drop Rst at cycle 10 of a normal operation → P=0 and flags 0 immediately, no Done. A new Start after release completes correctly. Start pulses while Busy=1 are ignored.
- EW=5, MW=10: 0x3C00×0x4000 → 0x4000, Done 14 cycles after Start. 0x7BFF×0x4000 with RNE → 0x7C00, OF=1.

Source files
------------

// File: rtl/fpmul_param.sv
// Parametrised multi-cycle floating-point multiplier: radix-2 shift-add mantissa
// product, four rounding modes, flush-to-zero underflow and a Start/Done handshake.
module fpmul_param #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic [1:0]     RM,
  input  logic [EW+MW:0] A,
  input  logic [EW+MW:0] B,
  output logic           Busy,
  output logic           Done,
  output logic [EW+MW:0] P,
  output logic           UF,
  output logic           OF,
  output logic           NaNF,
  output logic           InfF,
  output logic           DNF,
  output logic           ZF
);
  localparam int W  = 1 + EW + MW;
  localparam int N  = MW + 1;
  localparam int XW = EW + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [XW-1:0] BIAS   = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX   = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] ZERO_E = '0;
  localparam logic signed [XW-1:0] ONE_E  = XW'(1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;
  typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11} rm_t;
  typedef struct packed {
    logic uf;
    logic of;
    logic nanf;
    logic inff;
    logic dnf;
    logic zf;
  } flags_t;

  state_t                 state, state_nx;
  logic [W-1:0]           a_q, b_q, p_q;
  rm_t                    rm_q;
  logic                   sign_q, guard_q, sticky_q, chk_wait_q;
  logic signed [XW-1:0]   exp_q;
  logic [N-1:0]           mcand_q, acc_hi_q, acc_lo_q;
  logic [MW-1:0]          frac_q;
  logic [CW-1:0]          cnt_q;
  flags_t                 flags_q;

  logic                   sa, sb, sign_ab;
  logic [EW-1:0]          ea, eb;
  logic [MW-1:0]          fa, fb;
  logic                   a_den, b_den, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                   is_nan, is_inf, is_zero, is_special;
  logic [W-1:0]           spec_p, round_p;
  flags_t                 spec_flags, round_flags;
  logic signed [XW-1:0]   exp_init, norm_exp, round_exp;
  logic [N:0]             mult_sum;
  logic [2*N-1:0]         prod;
  logic [MW-1:0]          norm_frac, round_frac;
  logic                   norm_guard, norm_sticky, round_inc, round_carry, to_inf;

  assign sa = a_q[W-1];
  assign sb = b_q[W-1];
  assign ea = a_q[W-2 -: EW];
  assign eb = b_q[W-2 -: EW];
  assign fa = a_q[MW-1:0];
  assign fb = b_q[MW-1:0];
  assign sign_ab = sa ^ sb;

  // Denormal operands are flushed: an all-zero exponent always reads as zero.
  assign a_den  = (ea == '0) && (fa != '0);
  assign b_den  = (eb == '0) && (fb != '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  assign is_nan     = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
  assign is_inf     = a_inf | b_inf;
  assign is_zero    = a_zero | b_zero;
  assign is_special = is_nan | is_inf | is_zero;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    spec_p         = '0;
    spec_flags     = '0;
    spec_flags.dnf = a_den | b_den;
    if (is_nan) begin
      spec_p          = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      spec_flags.nanf = 1'b1;
    end else if (is_inf) begin
      spec_p          = {sign_ab, {EW{1'b1}}, {MW{1'b0}}};
      spec_flags.inff = 1'b1;
    end else begin
      spec_p        = {sign_ab, {(EW+MW){1'b0}}};
      spec_flags.zf = 1'b1;
    end
  end

  assign exp_init = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign mult_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign prod     = {acc_hi_q, acc_lo_q};

  // A product in [2,4) is taken one bit higher; the hidden bit is implied afterwards.
  always_comb begin
    if (prod[2*N-1]) begin
      norm_frac   = prod[2*N-2 -: MW];
      norm_guard  = prod[N-1];
      norm_sticky = |prod[N-2:0];
      norm_exp    = exp_q + ONE_E;
    end else begin
      norm_frac   = prod[2*N-3 -: MW];
      norm_guard  = prod[N-2];
      norm_sticky = |prod[N-3:0];
      norm_exp    = exp_q;
    end
  end

  always_comb begin
    round_inc = 1'b0;
    case (rm_q)
      RM_RNE:  round_inc = guard_q & (sticky_q | frac_q[0]);
      RM_RUP:  round_inc = (guard_q | sticky_q) & ~sign_q;
      RM_RDN:  round_inc = (guard_q | sticky_q) & sign_q;
      default: round_inc = 1'b0;
    endcase
  end

  // An all-ones fraction that rounds up wraps to zero and bumps the exponent.
  assign round_carry = round_inc & (&frac_q);
  assign round_frac  = frac_q + {{(MW-1){1'b0}}, round_inc};
  assign round_exp   = exp_q + (round_carry ? ONE_E : ZERO_E);
  assign to_inf      = (rm_q == RM_RNE) || (rm_q == RM_RUP && !sign_q) ||
                       (rm_q == RM_RDN && sign_q);

  always_comb begin
    round_p     = {sign_q, round_exp[EW-1:0], round_frac};
    round_flags = '0;
    if (round_exp >= EMAX) begin
      round_flags.of = 1'b1;
      if (to_inf) begin
        round_p          = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
        round_flags.inff = 1'b1;
      end else begin
        round_p = {sign_q, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
      end
    end else if (round_exp <= ZERO_E) begin
      round_flags.uf = 1'b1;
      round_flags.zf = 1'b1;
      round_p        = {sign_q, {(EW+MW){1'b0}}};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (Start) state_nx = S_CHECK;
      S_CHECK: begin
        if (!is_special)     state_nx = S_MULT;
        else if (chk_wait_q) state_nx = S_DONE;
      end
      S_MULT:  if (cnt_q == CW'(1)) state_nx = S_NORM;
      S_NORM:  state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      a_q        <= '0;
      b_q        <= '0;
      rm_q       <= RM_RNE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      frac_q     <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      chk_wait_q <= 1'b0;
      p_q        <= '0;
      flags_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          a_q        <= A;
          b_q        <= B;
          rm_q       <= rm_t'(RM);
          chk_wait_q <= 1'b0;
        end
        S_CHECK: begin
          // Special results spend a second cycle here, giving them a fixed 2-cycle latency.
          if (is_special) begin
            if (chk_wait_q) begin
              p_q        <= spec_p;
              flags_q    <= spec_flags;
              chk_wait_q <= 1'b0;
            end else begin
              chk_wait_q <= 1'b1;
            end
          end else begin
            sign_q   <= sign_ab;
            exp_q    <= exp_init;
            mcand_q  <= {1'b1, fa};
            acc_hi_q <= '0;
            acc_lo_q <= {1'b1, fb};
            cnt_q    <= CW'(N);
          end
        end
        S_MULT: begin
          acc_hi_q <= mult_sum[N:1];
          acc_lo_q <= {mult_sum[0], acc_lo_q[N-1:1]};
          cnt_q    <= cnt_q - CW'(1);
        end
        S_NORM: begin
          frac_q   <= norm_frac;
          guard_q  <= norm_guard;
          sticky_q <= norm_sticky;
          exp_q    <= norm_exp;
        end
        S_ROUND: begin
          p_q     <= round_p;
          flags_q <= round_flags;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);
  assign P    = p_q;
  assign UF   = flags_q.uf;
  assign OF   = flags_q.of;
  assign NaNF = flags_q.nanf;
  assign InfF = flags_q.inff;
  assign DNF  = flags_q.dnf;
  assign ZF   = flags_q.zf;
endmodule

// File: tb/tb_fpmul_param.sv
// Directed bench for fpmul_param: single- and half-precision instances, expected
// results queued at issue and compared when Done appears.
module tb_fpmul_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, busy0, done0, uf0, of0, nanf0, inff0, dnf0, zf0;
  logic [1:0]  rm0;
  logic [31:0] a0, b0, p0;
  logic        start1, busy1, done1, uf1, of1, nanf1, inff1, dnf1, zf1;
  logic [1:0]  rm1;
  logic [15:0] a1, b1, p1;

  fpmul_param #(.EW(8), .MW(23)) dut0 (
    .Clk(clk), .Rst(rst_n), .Start(start0), .RM(rm0), .A(a0), .B(b0),
    .Busy(busy0), .Done(done0), .P(p0),
    .UF(uf0), .OF(of0), .NaNF(nanf0), .InfF(inff0), .DNF(dnf0), .ZF(zf0)
  );

  fpmul_param #(.EW(5), .MW(10)) dut1 (
    .Clk(clk), .Rst(rst_n), .Start(start1), .RM(rm1), .A(a1), .B(b1),
    .Busy(busy1), .Done(done1), .P(p1),
    .UF(uf1), .OF(of1), .NaNF(nanf1), .InfF(inff1), .DNF(dnf1), .ZF(zf1)
  );

  // Flag vector order: {UF, OF, NaNF, InfF, DNF, ZF}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_UF   = 6'b100000;
  localparam logic [5:0] F_OF   = 6'b010000;
  localparam logic [5:0] F_NAN  = 6'b001000;
  localparam logic [5:0] F_INF  = 6'b000100;
  localparam logic [5:0] F_DN   = 6'b000010;
  localparam logic [5:0] F_Z    = 6'b000001;

  typedef struct {
    logic [31:0] p;
    logic [5:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic logic [5:0] flags_of(input bit sel);
    return sel ? {uf1, of1, nanf1, inff1, dnf1, zf1} : {uf0, of0, nanf0, inff0, dnf0, zf0};
  endfunction

  function automatic logic [31:0] obs_p(input bit sel);
    return sel ? {16'h0000, p1} : p0;
  endfunction

  function automatic logic obs_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction

  function automatic logic obs_done(input bit sel);
    return sel ? done1 : done0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Issue one operation, push its expected result, then wait (bounded) for Done.
  task automatic run_op(input string tag, input bit sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input logic [31:0] p_exp, input logic [5:0] fl_exp,
                        input int lat, input int poke_at);
    exp_t e;
    int   j;
    logic busy_ok;
    @(negedge clk);
    if (sel) begin
      a1 = a[15:0]; b1 = b[15:0]; rm1 = rm;
    end else begin
      a0 = a; b0 = b; rm0 = rm;
    end
    drive_start(sel, 1'b1);
    sb.push_back('{p_exp, fl_exp});
    @(posedge clk);
    #1;
    drive_start(sel, 1'b0);
    busy_ok = 1'b1;
    for (j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == poke_at) begin
        if (sel) a1 = 16'h1234;
        else     a0 = 32'h12345678;
        drive_start(sel, 1'b1);
      end
      if (j == poke_at + 1) drive_start(sel, 1'b0);
      busy_ok = busy_ok & obs_busy(sel);
      if (obs_done(sel)) break;
    end
    check({tag, " latency"}, j, lat);
    e = sb.pop_front();
    check({tag, " P"}, obs_p(sel), e.p);
    check({tag, " flags"}, {26'b0, flags_of(sel)}, {26'b0, e.fl});
    check({tag, " busy held"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check({tag, " done/busy after"}, {30'b0, obs_done(sel), obs_busy(sel)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    rst_n = 1'b0;
    start0 = 1'b0; rm0 = 2'b00; a0 = '0; b0 = '0;
    start1 = 1'b0; rm1 = 2'b00; a1 = '0; b1 = '0;
    #1;
    check("reset P0", p0, 32'h0);
    check("reset flags0", {26'b0, flags_of(1'b0)}, 32'h0);
    check("reset busy/done0", {30'b0, busy0, done0}, 32'h0);
    check("reset P1", {16'b0, p1}, 32'h0);
    #21 rst_n = 1'b1;

    run_op("1.5x2",        0, 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, F_NONE, 27, -1);
    run_op("1.5x1.5",      0, 32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40100000, F_NONE, 27, -1);
    run_op("sticky RNE",   0, 32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, F_NONE, 27, -1);
    run_op("sticky RTZ",   0, 32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, F_NONE, 27, -1);
    run_op("sticky RUP",   0, 32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, F_NONE, 27, -1);
    run_op("neg RDN",      0, 32'hBF800001, 32'h3F800001, 2'b11, 32'hBF800003, F_NONE, 27, -1);
    run_op("tie odd RNE",  0, 32'h3F800001, 32'h3FC00000, 2'b00, 32'h3FC00002, F_NONE, 27, -1);
    run_op("tie odd RTZ",  0, 32'h3F800001, 32'h3FC00000, 2'b01, 32'h3FC00001, F_NONE, 27, -1);
    run_op("tie even RNE", 0, 32'h3F800003, 32'h3FC00000, 2'b00, 32'h3FC00004, F_NONE, 27, -1);
    run_op("sqrt2^2 RNE",  0, 32'h3FB504F3, 32'h3FB504F3, 2'b00, 32'h3FFFFFFF, F_NONE, 27, -1);
    run_op("carry RUP",    0, 32'h3FB504F3, 32'h3FB504F3, 2'b10, 32'h40000000, F_NONE, 27, -1);

    run_op("OF RNE",       0, 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, F_OF | F_INF, 27, -1);
    run_op("OF RTZ",       0, 32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, F_OF, 27, -1);
    run_op("OF RDN pos",   0, 32'h7F000000, 32'h7F000000, 2'b11, 32'h7F7FFFFF, F_OF, 27, -1);
    run_op("OF RUP neg",   0, 32'hFF000000, 32'h7F000000, 2'b10, 32'hFF7FFFFF, F_OF, 27, -1);
    run_op("OF RDN neg",   0, 32'hFF000000, 32'h7F000000, 2'b11, 32'hFF800000, F_OF | F_INF, 27, -1);
    run_op("UF pos",       0, 32'h00800000, 32'h00800000, 2'b00, 32'h00000000, F_UF | F_Z, 27, -1);
    run_op("UF neg",       0, 32'h80800000, 32'h00800000, 2'b00, 32'h80000000, F_UF | F_Z, 27, -1);

    run_op("inf x zero",   0, 32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, F_NAN, 2, -1);
    run_op("denorm x 1",   0, 32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, F_DN | F_Z, 2, -1);
    run_op("inf x -1",     0, 32'h7F800000, 32'hBF800000, 2'b00, 32'hFF800000, F_INF, 2, -1);
    run_op("nan x 1",      0, 32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000, F_NAN, 2, -1);
    run_op("denorm x inf", 0, 32'h00000001, 32'h7F800000, 2'b00, 32'h7FC00000, F_NAN | F_DN, 2, -1);
    run_op("-0 x 1",       0, 32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, F_Z, 2, -1);
    run_op("OF before rst",0, 32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, F_OF | F_INF, 27, -1);

    // Abort a normal operation with reset partway through the multiply.
    @(negedge clk);
    a0 = 32'h3FC00000; b0 = 32'h40000000; rm0 = 2'b00; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort P", p0, 32'h0);
    check("abort flags", {26'b0, flags_of(1'b0)}, 32'h0);
    check("abort busy/done", {30'b0, busy0, done0}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    check("abort no done", dcount, 0);

    run_op("after rst+poke", 0, 32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, F_NONE, 27, 3);

    run_op("half 1x2",     1, 32'h00003C00, 32'h00004000, 2'b00, 32'h00004000, F_NONE, 14, -1);
    run_op("half OF RNE",  1, 32'h00007BFF, 32'h00004000, 2'b00, 32'h00007C00, F_OF | F_INF, 14, -1);
    run_op("half inf x 0", 1, 32'h00007C00, 32'h00000000, 2'b00, 32'h00007E00, F_NAN, 2, -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
